adder_stim_chk: RTL and testbench

//  Initiator/checker that drives the registered W-bit adder from the other end of its a/b/y interface.

---
 rtl/adder_stim_chk.sv | 120 ++++++++++++
 tb/tb_adder_stim_chk.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_stim_chk.sv
// On-chip self-test initiator/checker for a registered W-bit adder.
// LFSR operands go out on a/b; the sum is checked LAT+1 edges after each issue.
module adder_stim_chk #(
  parameter int         W       = 4,
  parameter int         NUM_VEC = 16,
  parameter int         LAT     = 1,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  input  logic [W:0]   y_i,
  output logic         busy,
  output logic         done,
  output logic [7:0]   pass_cnt,
  output logic [7:0]   err_cnt,
  output logic [7:0]   first_err
);

  localparam logic [7:0] SEED0 = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] LASTI = 8'(NUM_VEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} st_t;

  typedef struct packed {
    logic       v;
    logic [W:0] s;
    logic [7:0] idx;
  } ent_t;

  st_t          state_q;
  logic [7:0]   lfsr_q;
  logic [7:0]   idx_q;
  logic [7:0]   pass_q;
  logic [7:0]   err_q;
  logic [7:0]   ferr_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  ent_t         pipe_q [LAT+1];

  logic [7:0]   lfsr_d;
  logic [W:0]   sum_d;
  logic         chk;
  logic         hit;
  logic         last;

  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    sum_d  = {1'b0, lfsr_q[W-1:0]} + {1'b0, lfsr_q[W+3:4]};
    chk    = pipe_q[LAT].v;
    hit    = (y_i == pipe_q[LAT].s);
    // last outstanding check: nothing valid still behind it
    last   = chk;
    for (int i = 0; i < LAT; i++) begin
      if (pipe_q[i].v) last = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED0;
      idx_q   <= '0;
      pass_q  <= '0;
      err_q   <= '0;
      ferr_q  <= 8'hFF;
      a_q     <= '0;
      b_q     <= '0;
      for (int i = 0; i <= LAT; i++) pipe_q[i] <= '0;
    end else begin
      a_q       <= '0;
      b_q       <= '0;
      pipe_q[0] <= '0;
      for (int i = 1; i <= LAT; i++) pipe_q[i] <= pipe_q[i-1];
      if (chk) begin
        if (hit) begin
          pass_q <= pass_q + 8'd1;
        end else begin
          if (err_q != 8'hFF) err_q <= err_q + 8'd1;
          if (ferr_q == 8'hFF) ferr_q <= pipe_q[LAT].idx;
        end
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            lfsr_q  <= SEED0;
            idx_q   <= '0;
            pass_q  <= '0;
            err_q   <= '0;
            ferr_q  <= 8'hFF;
          end
        end
        RUN: begin
          a_q       <= lfsr_q[W-1:0];
          b_q       <= lfsr_q[W+3:4];
          pipe_q[0] <= '{v: 1'b1, s: sum_d, idx: idx_q};
          lfsr_q    <= lfsr_d;
          idx_q     <= idx_q + 8'd1;
          if (idx_q == LASTI) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last) state_q <= DONE;
        end
      endcase
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass_cnt  = pass_q;
  assign err_cnt   = err_q;
  assign first_err = ferr_q;

endmodule

// File: tb/tb_adder_stim_chk.sv
// Bench for adder_stim_chk: behavioural adders with injectable faults
// and a vector-level reference model of the expected run results.
module tb_adder_stim_chk;

  logic clk = 1'b0;
  logic rst;
  logic start_m, start_2, start_3;

  always #5 clk = ~clk;

  logic [3:0] a_m, b_m, a_2, b_2, a_3, b_3;
  logic [4:0] y_m, y_2, y_3;
  logic       busy_m, done_m, busy_2, done_2, busy_3, done_3;
  logic [7:0] pass_m, err_m, fe_m;
  logic [7:0] pass_2, err_2, fe_2;
  logic [7:0] pass_3, err_3, fe_3;

  adder_stim_chk u_dut (
    .clk(clk), .rst(rst), .start(start_m),
    .a_o(a_m), .b_o(b_m), .y_i(y_m),
    .busy(busy_m), .done(done_m),
    .pass_cnt(pass_m), .err_cnt(err_m), .first_err(fe_m)
  );

  adder_stim_chk #(.NUM_VEC(255), .LAT(2)) u_long (
    .clk(clk), .rst(rst), .start(start_2),
    .a_o(a_2), .b_o(b_2), .y_i(y_2),
    .busy(busy_2), .done(done_2),
    .pass_cnt(pass_2), .err_cnt(err_2), .first_err(fe_2)
  );

  adder_stim_chk #(.NUM_VEC(1), .SEED(8'h00)) u_one (
    .clk(clk), .rst(rst), .start(start_3),
    .a_o(a_3), .b_o(b_3), .y_i(y_3),
    .busy(busy_3), .done(done_3),
    .pass_cnt(pass_3), .err_cnt(err_3), .first_err(fe_3)
  );

  // adder fault modes: 0 good, 1 bit0 stuck low, 2 corrupt chosen operands
  int         mode = 0;
  bit         lat2 = 1'b0;
  bit         badop [256];
  logic [4:0] mask = 5'd1;

  function automatic logic [4:0] fadd(logic [3:0] a, logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (mode == 1) s[0] = 1'b0;
    if (mode == 2 && badop[{b, a}]) s = s ^ mask;
    return s;
  endfunction

  logic [4:0] m1 = '0, m2 = '0, q1 = '0, q2 = '0, r1 = '0;
  always @(posedge clk) begin
    m1 <= fadd(a_m, b_m);
    m2 <= m1;
    q1 <= {1'b0, a_2} + {1'b0, b_2};
    q2 <= q1;
    r1 <= {1'b0, a_3} + {1'b0, b_3};
  end
  assign y_m = lat2 ? m2 : m1;
  assign y_2 = q2;
  assign y_3 = r1;

  int total = 0;
  int bad_n = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  int ops [256];

  // md 3 models an adder one cycle slower than the checker expects
  function automatic void model(input int n, input logic [7:0] seed,
                                input int md, output int p,
                                output int e, output int f);
    logic [7:0] l;
    logic [4:0] s, y, prev;
    l = (seed == 8'h00) ? 8'h01 : seed;
    prev = '0;
    p = 0; e = 0; f = 255;
    for (int k = 0; k < n; k++) begin
      ops[k] = int'(l);
      s = {1'b0, l[3:0]} + {1'b0, l[7:4]};
      case (md)
        1:       y = {s[4:1], 1'b0};
        2:       y = badop[l] ? (s ^ mask) : s;
        3:       y = prev;
        default: y = s;
      endcase
      if (y == s) p++;
      else begin
        e++;
        if (f == 255) f = k;
      end
      prev = s;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
  endfunction

  task automatic run_main(input int md, input bit dl, input bit pulse,
                          input string tag);
    int p, e, f, cyc, p1, p2;
    model(16, 8'hA5, dl ? 3 : md, p, e, f);
    mode = md;
    lat2 = dl;
    repeat (3) @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    p1 = $urandom_range(2, 6);
    p2 = $urandom_range(8, 14);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      check({tag, ".op"}, {24'd0, b_m, a_m}, ops[k]);
      if (k == 0) check({tag, ".busy"}, busy_m, 1);
      start_m = pulse && (k == p1 || k == p2);
    end
    start_m = 1'b0;
    cyc = 0;
    while (!done_m && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, ".len"}, 16 + cyc, 18);
    check({tag, ".pass"}, pass_m, p);
    check({tag, ".err"}, err_m, e);
    check({tag, ".first"}, fe_m, f);
    check({tag, ".busy0"}, busy_m, 0);
    check({tag, ".opidle"}, {b_m, a_m}, 0);
  endtask

  initial begin
    int p, e, f, cyc;
    rst = 1'b1;
    start_m = 1'b0;
    start_2 = 1'b0;
    start_3 = 1'b0;
    foreach (badop[i]) badop[i] = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.op", {b_m, a_m}, 0);
    check("rst.busy", busy_m, 0);
    check("rst.done", done_m, 0);
    check("rst.pass", pass_m, 0);
    check("rst.err", err_m, 0);
    check("rst.first", fe_m, 8'hFF);
    rst = 1'b0;

    run_main(0, 1'b0, 1'b0, "t1");
    run_main(0, 1'b0, 1'b1, "t4");
    run_main(1, 1'b0, 1'b0, "t2");
    for (int r = 0; r < 4; r++) begin
      foreach (badop[i]) badop[i] = ($urandom_range(0, 3) == 0);
      badop[0] = 1'b0;
      mask = 5'($urandom_range(1, 31));
      run_main(2, 1'b0, r[0], "rnd");
    end
    run_main(0, 1'b1, 1'b0, "t3");

    // reset in the middle of a run
    mode = 0;
    lat2 = 1'b0;
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat ($urandom_range(3, 12)) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5.op", {b_m, a_m}, 0);
    check("t5.busy", busy_m, 0);
    check("t5.pass", pass_m, 0);
    check("t5.first", fe_m, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5.idle", {busy_m, done_m}, 0);
    run_main(0, 1'b0, 1'b0, "t5");

    // long run, LAT=2 on both sides, visits every nonzero LFSR state
    model(255, 8'hA5, 0, p, e, f);
    @(negedge clk);
    start_2 = 1'b1;
    @(negedge clk);
    start_2 = 1'b0;
    @(posedge clk);
    #1;
    check("t7.op", {b_2, a_2}, ops[0]);
    cyc = 1;
    while (!done_2 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t7.len", cyc, 258);
    check("t7.pass", pass_2, p);
    check("t7.err", err_2, e);
    check("t7.first", fe_2, f);
    check("t7.busy", busy_2, 0);

    // single vector, zero seed
    model(1, 8'h00, 0, p, e, f);
    @(negedge clk);
    start_3 = 1'b1;
    @(negedge clk);
    start_3 = 1'b0;
    @(posedge clk);
    #1;
    check("t6.op", {b_3, a_3}, ops[0]);
    cyc = 1;
    while (!done_3 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t6.len", cyc, 3);
    check("t6.pass", pass_3, p);
    check("t6.err", err_3, e);
    check("t6.first", fe_3, f);
    check("t6.busy", busy_3, 0);

    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end

endmodule
